// File: rtl/fsm_sequence_pkg.sv
// Shared definitions for the run-length-4 sequence detector: state indices,
// state-vector width and the one-hot encodings.
package fsm_sequence_pkg;

    localparam int STATE_W = 9;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;
    localparam int IDX_D = 3;
    localparam int IDX_E = 4;
    localparam int IDX_F = 5;
    localparam int IDX_G = 6;
    localparam int IDX_H = 7;
    localparam int IDX_I = 8;

    // A owns its own hot bit (bit 0), so the all-zero vector is illegal like any other non-one-hot code.
    typedef enum logic [STATE_W-1:0] {
        ST_A = 9'b000000001,
        ST_B = 9'b000000010,
        ST_C = 9'b000000100,
        ST_D = 9'b000001000,
        ST_E = 9'b000010000,
        ST_F = 9'b000100000,
        ST_G = 9'b001000000,
        ST_H = 9'b010000000,
        ST_I = 9'b100000000
    } state_t;

    function automatic logic is_detect(input state_t s);
        return s[IDX_E] | s[IDX_I];
    endfunction

endpackage

// File: rtl/fsm_sequence_detector.sv
// Moore FSM: z=1 once w has held the same value for four consecutive rising
// edges of clock; overlapping runs keep z high.
module fsm_sequence_detector
    import fsm_sequence_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic w,
    output logic z
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_A;
        case (state_q)
            ST_A:    state_d = w ? ST_F : ST_B;
            ST_B:    state_d = w ? ST_F : ST_C;
            ST_C:    state_d = w ? ST_F : ST_D;
            ST_D:    state_d = w ? ST_F : ST_E;
            ST_E:    state_d = w ? ST_F : ST_E;
            ST_F:    state_d = w ? ST_G : ST_B;
            ST_G:    state_d = w ? ST_H : ST_B;
            ST_H:    state_d = w ? ST_I : ST_B;
            ST_I:    state_d = w ? ST_I : ST_B;
            // Any non-one-hot code recovers to idle.
            default: state_d = ST_A;
        endcase
    end

    assign z = is_detect(state_q);

endmodule

// File: tb/tb_fsm_sequence_detector.sv
// Bench for fsm_sequence_detector: vector table, a reset-in-E sequence and a
// random run checked against a run-length model.
module tb_fsm_sequence_detector;

    logic clock;
    logic reset;
    logic w;
    logic z;

    int errors = 0;
    int checks = 0;

    localparam int SA = 0, SB = 1, SC = 2, SD = 3, SE = 4;
    localparam int SF = 5, SG = 6, SH = 7, SI = 8;

    typedef struct {
        logic r;
        logic wv;
        logic ez;
        int   est;
    } vec_t;

    typedef struct {
        logic ez;
        int   est;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    fsm_sequence_detector dut (
        .clock(clock),
        .reset(reset),
        .w(w),
        .z(z)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check_out(input string name);
        exp_t e;
        logic [8:0] st;
        logic [8:0] est_v;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (z !== e.ez) begin
            errors++;
            $display("FAIL %s z: got %b expected %b", name, z, e.ez);
        end
        st = dut.state_q;
        est_v = 9'd1 << e.est;
        checks++;
        if (st !== est_v) begin
            errors++;
            $display("FAIL %s state: got %b expected %b", name, st, est_v);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic ez, input int est,
                        input string name);
        exp_t e;
        @(negedge clock);
        reset = r;
        w = wv;
        e.ez = ez;
        e.est = est;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out(name);
    endtask

    initial begin
        int cnt;
        logic last;
        logic r;
        logic wv;
        int est;

        reset = 1'b1;
        w = 1'b0;

        // reset, then 0,1,0
        vecs.push_back('{1'b1, 1'b1, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        // reset, 1,1,1,0,0 then 0,0
        vecs.push_back('{1'b1, 1'b0, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SG});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SH});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SC});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SD});
        vecs.push_back('{1'b0, 1'b0, 1'b1, SE});
        // reset, 1,1,0,1
        vecs.push_back('{1'b1, 1'b0, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SG});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        // reset, seven 1s, then 0
        vecs.push_back('{1'b1, 1'b0, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SG});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SH});
        vecs.push_back('{1'b0, 1'b1, 1'b1, SI});
        vecs.push_back('{1'b0, 1'b1, 1'b1, SI});
        vecs.push_back('{1'b0, 1'b1, 1'b1, SI});
        vecs.push_back('{1'b0, 1'b1, 1'b1, SI});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        // reset, four 0s then four 1s (E -> F directly)
        vecs.push_back('{1'b1, 1'b1, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SB});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SC});
        vecs.push_back('{1'b0, 1'b0, 1'b0, SD});
        vecs.push_back('{1'b0, 1'b0, 1'b1, SE});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SG});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SH});
        vecs.push_back('{1'b0, 1'b1, 1'b1, SI});
        // reset wins over w=1 while in I
        vecs.push_back('{1'b1, 1'b1, 1'b0, SA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, SF});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].wv, vecs[i].ez, vecs[i].est, $sformatf("vec%0d", i));
        end

        // reset for one edge while in E with w=0, then four 0s to re-detect
        step(1'b1, 1'b0, 1'b0, SA, "rstE_init");
        step(1'b0, 1'b0, 1'b0, SB, "rstE_0a");
        step(1'b0, 1'b0, 1'b0, SC, "rstE_0b");
        step(1'b0, 1'b0, 1'b0, SD, "rstE_0c");
        step(1'b0, 1'b0, 1'b1, SE, "rstE_inE");
        step(1'b1, 1'b0, 1'b0, SA, "rstE_reset");
        step(1'b0, 1'b0, 1'b0, SB, "rstE_post1");
        step(1'b0, 1'b0, 1'b0, SC, "rstE_post2");
        step(1'b0, 1'b0, 1'b0, SD, "rstE_post3");
        step(1'b0, 1'b0, 1'b1, SE, "rstE_post4");

        // random run against a run-length model
        step(1'b1, 1'b0, 1'b0, SA, "rnd_reset");
        cnt = 0;
        last = 1'b0;
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 24) == 0);
            wv = ($urandom_range(0, 3) != 0) ? last : ~last;
            if (k % 37 == 0) wv = $urandom_range(0, 1);
            if (r) begin
                cnt = 0;
            end else if (cnt == 0 || wv != last) begin
                cnt = 1;
                last = wv;
            end else begin
                cnt++;
            end
            if (cnt == 0) est = SA;
            else est = (last ? SF : SB) + ((cnt > 4) ? 4 : cnt) - 1;
            step(r, wv, (cnt >= 4), est, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
